// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (ibus/dbus) round-robin arbiter for a single memory port
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ibus_adr_i,
    input  logic                  ibus_cyc_i,
    input  logic                  ibus_stb_i,
    output logic [DATA_WIDTH-1:0] ibus_dat_o,
    output logic                  ibus_ack_o,
    output logic                  ibus_err_o,
    input  logic [ADDR_WIDTH-1:0] dbus_adr_i,
    input  logic [DATA_WIDTH-1:0] dbus_dat_i,
    input  logic                  dbus_we_i,
    input  logic                  dbus_cyc_i,
    input  logic                  dbus_stb_i,
    input  logic [2:0]            dbus_funct3_i,
    output logic [DATA_WIDTH-1:0] dbus_dat_o,
    output logic                  dbus_ack_o,
    output logic                  dbus_err_o,
    output logic [ADDR_WIDTH-1:0] mem_adr_o,
    output logic [DATA_WIDTH-1:0] mem_dat_o,
    output logic                  mem_we_o,
    output logic                  mem_cyc_o,
    output logic                  mem_stb_o,
    output logic [2:0]            mem_funct3_o,
    input  logic [DATA_WIDTH-1:0] mem_dat_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            grant_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t        state, state_nxt;
    logic          last_d, last_d_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ireq, dreq, timeout;

    assign ireq    = ibus_cyc_i & ibus_stb_i;
    assign dreq    = dbus_cyc_i & dbus_stb_i;
    assign timeout = (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_d_nxt   = last_d;
        cnt_nxt      = cnt;
        ibus_dat_o   = '0;
        ibus_ack_o   = 1'b0;
        ibus_err_o   = 1'b0;
        dbus_dat_o   = '0;
        dbus_ack_o   = 1'b0;
        dbus_err_o   = 1'b0;
        mem_adr_o    = '0;
        mem_dat_o    = '0;
        mem_we_o     = 1'b0;
        mem_cyc_o    = 1'b0;
        mem_stb_o    = 1'b0;
        mem_funct3_o = 3'b000;
        grant_o      = 2'b00;
        case (state)
            IDLE: begin
                // ibus wins a tie only when dbus held the last grant
                if (ireq && (!dreq || last_d)) begin
                    state_nxt = GNT_I;
                    cnt_nxt   = '0;
                end else if (dreq) begin
                    state_nxt = GNT_D;
                    cnt_nxt   = '0;
                end
            end
            GNT_I: begin
                grant_o      = 2'b01;
                mem_adr_o    = ibus_adr_i;
                mem_cyc_o    = ibus_cyc_i;
                mem_stb_o    = ibus_stb_i;
                mem_funct3_o = 3'b010;
                ibus_ack_o   = mem_ack_i;
                ibus_dat_o   = mem_ack_i ? mem_dat_i : '0;
                if (mem_ack_i) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b0;
                end else if (!ibus_cyc_i) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    ibus_err_o = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GNT_D: begin
                grant_o      = 2'b10;
                mem_adr_o    = dbus_adr_i;
                mem_dat_o    = dbus_dat_i;
                mem_we_o     = dbus_we_i;
                mem_cyc_o    = dbus_cyc_i;
                mem_stb_o    = dbus_stb_i;
                mem_funct3_o = dbus_funct3_i;
                dbus_ack_o   = mem_ack_i;
                dbus_dat_o   = mem_ack_i ? mem_dat_i : '0;
                if (mem_ack_i) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b1;
                end else if (!dbus_cyc_i) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    dbus_err_o = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, byte address width forwarded to the memory.
REQ-003 SHALL have parameter TIMEOUT, default 8, BUSY cycles without mem_ack_i before error.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have instruction-port inputs: ibus_adr_i  in  ADDR_WIDTH  fetch address; ibus_cyc_i  in  1  cycle; ibus_stb_i  in  1  strobe.
REQ-006 SHALL have instruction-port outputs: ibus_dat_o  out  DATA_WIDTH  read data; ibus_ack_o  out  1  acknowledge; ibus_err_o  out  1  timeout error.
REQ-007 SHALL have data-port inputs: dbus_adr_i  in  ADDR_WIDTH  address; dbus_dat_i  in  DATA_WIDTH  write data; dbus_we_i  in  1  write enable; dbus_cyc_i  in  1  cycle; dbus_stb_i  in  1  strobe; dbus_funct3_i  in  3  load/store size.
REQ-008 SHALL have data-port outputs: dbus_dat_o  out  DATA_WIDTH  read data; dbus_ack_o  out  1  acknowledge; dbus_err_o  out  1  timeout error.
REQ-009 SHALL have memory-side outputs: mem_adr_o  out  ADDR_WIDTH; mem_dat_o  out  DATA_WIDTH; mem_we_o  out  1; mem_cyc_o  out  1; mem_stb_o  out  1; mem_funct3_o  out  3.
REQ-010 SHALL have memory-side inputs mem_dat_i  in  DATA_WIDTH and mem_ack_i  in  1, plus grant_o  out  2  status: 01 ibus, 10 dbus, 00 idle.

Function
REQ-011 SHALL implement a state machine with states IDLE, GNT_I and GNT_D.
REQ-012 In IDLE, a request is cyc_i&stb_i; if exactly one port requests, it is granted at the next edge (IDLE->GNT_I or GNT_D).
REQ-013 On simultaneous requests, grant SHALL go round-robin: the port not granted last wins; last-granted holds dbus after reset, so ibus wins the first tie.
REQ-014 In GNT_x, mem_* outputs SHALL combinationally mirror the granted port's adr/dat/we/cyc/stb/funct3.
REQ-015 For ibus grants, mem_we_o=0, mem_funct3_o=3'b010 and mem_dat_o=0.
REQ-016 In IDLE, mem_cyc_o, mem_stb_o and mem_we_o SHALL be 0, and all other mem_* outputs SHALL be 0.
REQ-017 In GNT_x, x_ack_o = mem_ack_i and x_dat_o = mem_dat_i when mem_ack_i=1, else 0; the non-granted port sees ack=0, dat=0, err=0.
REQ-018 On mem_ack_i in GNT_x, the next state SHALL be IDLE and last-granted SHALL be updated to x.
REQ-019 IDLE SHALL last at least one cycle between grants, so the memory's trailing registered ack is absorbed.
REQ-020 mem_ack_i in IDLE SHALL be ignored.
REQ-021 If the granted master drops cyc_i before ack, the next state SHALL be IDLE with no ack or err issued.
REQ-022 A $clog2(TIMEOUT+1)-bit counter SHALL clear on entering GNT_x and increment each GNT_x cycle without mem_ack_i.
REQ-023 When the counter reaches TIMEOUT, x_err_o SHALL pulse for one cycle, ack SHALL stay 0, and the next state SHALL be IDLE.
REQ-024 ack SHALL take priority over timeout in the same cycle.
REQ-025 Latency against a one-cycle-ack memory: request in cycle 0 (IDLE), grant in cycle 1, ack in cycle 2; back-to-back same-port accesses take 3 cycles each.
REQ-026 A new request arriving during another port's grant SHALL be held pending, not dropped; that master keeps stb asserted until ack.

Reset
REQ-027 On rst=1, regardless of the clock, state SHALL become IDLE, last-granted dbus and counter 0.
REQ-028 During and after reset, all acks, errs, dat_o, mem_* outputs and grant_o SHALL be 0.
REQ-029 Reset during GNT_x SHALL abort the transfer with no ack or err.

Verification
REQ-030 Single ibus read at address 0x010 after reset, memory returns 0x00000033 -> grant_o=01 in cycle 1, ibus_ack_o=1 with ibus_dat_o=0x00000033 in cycle 2, dbus outputs 0.
REQ-031 ibus and dbus request in the same cycle from reset -> ibus served first, IDLE for one cycle, then dbus served; next tie goes to ibus.
REQ-032 dbus store, funct3=000, adr=0x005, dat=0xA5 -> mem_we_o=1, mem_funct3_o=000, mem_dat_o=0x000000A5 during GNT_D; ibus read of 0x004 then returns byte 1 = 0xA5.
REQ-033 Memory never acks (mem_ack_i tied 0), TIMEOUT=8 -> dbus_err_o pulses exactly once, 8 cycles after the grant, then the FSM returns to IDLE and later requests are served.
REQ-034 rst asserted mid-GNT_I -> all outputs 0 immediately, no ack; after release, a pending dbus request is granted first (tie rule unaffected).
REQ-035 Master drops cyc_i in GNT_D before ack -> IDLE next cycle, dbus_ack_o and dbus_err_o stay 0.
